// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision field definitions for the FPU lane.
package fpu_pkg;

  localparam int unsigned FLOAT_BIAS = 127;
  localparam int unsigned EXP_W      = 8;
  localparam int unsigned MAN_W      = 23;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } float_t;

endpackage

// File: rtl/itof_lzc.sv
// Combinational 32-bit leading-zero counter built from a tree of 2-bit encoders.
// Returns 32 when the input is zero.
module itof_lzc (
  input  logic [31:0] a,
  output logic [5:0]  lz
);

  // Each level's MSB flags "all zero so far"; lower bits count zeros inside the group.
  logic [1:0] c1 [16];
  logic [2:0] c2 [8];
  logic [3:0] c3 [4];
  logic [4:0] c4 [2];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      c1[i] = a[2*i+1] ? 2'd0 : (a[2*i] ? 2'd1 : 2'd2);
    end
    for (int i = 0; i < 8; i++) begin
      c2[i] = c1[2*i+1][1] ? (c1[2*i][1] ? 3'b100 : {2'b01, c1[2*i][0]})
                           : {1'b0, c1[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      c3[i] = c2[2*i+1][2] ? (c2[2*i][2] ? 4'b1000 : {2'b01, c2[2*i][1:0]})
                           : {1'b0, c2[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      c4[i] = c3[2*i+1][3] ? (c3[2*i][3] ? 5'b10000 : {2'b01, c3[2*i][2:0]})
                           : {1'b0, c3[2*i+1]};
    end
    lz = c4[1][4] ? (c4[0][4] ? 6'b100000 : {2'b01, c4[0][3:0]}) : {1'b0, c4[1]};
  end

endmodule

// File: rtl/itof_pipe.sv
// Signed 32-bit integer to IEEE single converter, 3-stage pipeline, RNE rounding.
// Define ITOF_INEXACT_EN to add the registered inexact flag output.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAN_W  = fpu_pkg::MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       y
`ifdef ITOF_INEXACT_EN
  ,
  output logic              inexact
`endif
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("itof_pipe: only DATA_W = 32 is supported");
  end
  if (MAN_W != 23) begin : g_bad_man_w
    $error("itof_pipe: only MAN_W = 23 is supported");
  end

  logic adv;

  logic              v1_q, v2_q, v3_q;
  logic              s1_q, z1_q;
  logic [DATA_W-1:0] a1_q;
  logic              s2_q, z2_q;
  logic [EXP_W-1:0]  e2_q;
  logic [30:0]       n2_q;
  float_t            y_q;

  logic [5:0]             lz;
  logic [EXP_W-1:0]       e_d;
  logic [30:0]            n_d;
  logic [MAN_W-1:0]       frac;
  logic                   g, st, up;
  logic [EXP_W+MAN_W-1:0] em;
  float_t                 y_d;

  // Single global enable: a stall freezes every stage, bubbles included.
  always_comb begin
    adv      = out_ready | ~v3_q;
    in_ready = adv;
  end

  itof_lzc u_lzc (
    .a  (a1_q),
    .lz (lz)
  );

  // The normalised leading one is implicit, so only the bits below it are kept.
  always_comb begin
    n_d = 31'(a1_q << lz);
    e_d = EXP_W'(FLOAT_BIAS + 31 - 32'(lz));
  end

  // Rounding carry may ripple out of the fraction into the exponent.
  always_comb begin
    frac = n2_q[30:8];
    g    = n2_q[7];
    st   = |n2_q[6:0];
    up   = g & (st | frac[0]);
    em   = {e2_q, frac} + {{(EXP_W+MAN_W-1){1'b0}}, up};
    y_d  = z2_q ? '0 : float_t'({s2_q, em});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= 1'b0;
      z1_q <= 1'b0;
      a1_q <= '0;
      s2_q <= 1'b0;
      z2_q <= 1'b0;
      e2_q <= '0;
      n2_q <= '0;
      y_q  <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      s1_q <= x[DATA_W-1];
      z1_q <= (x == '0);
      a1_q <= x[DATA_W-1] ? -x : x;
      v2_q <= v1_q;
      s2_q <= s1_q;
      z2_q <= z1_q;
      e2_q <= e_d;
      n2_q <= n_d;
      v3_q <= v2_q;
      y_q  <= y_d;
    end
  end

  assign out_valid = v3_q;
  assign y         = y_q;

`ifdef ITOF_INEXACT_EN
  logic inexact_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_q <= 1'b0;
    end else if (adv) begin
      inexact_q <= ~z2_q & (g | st);
    end
  end

  assign inexact = v3_q & inexact_q;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed table, handshake corner cases, random stream.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] y;
`ifdef ITOF_INEXACT_EN
  logic        inexact;
`endif

  itof_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef ITOF_INEXACT_EN
    ,
    .inexact   (inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        inx;
  } vec_t;

  vec_t        vecs [12];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  logic        popped;
  logic [32:0] exp_q [$];

  // Reference: exact integer magnitude, then round-to-nearest-even by remainder comparison.
  function automatic logic [32:0] model(input logic [31:0] xv);
    longint mag, q, r, half;
    int     p, shift;
    logic   s;
    s   = xv[31];
    mag = longint'($signed(xv));
    if (mag < 0) mag = -mag;
    if (mag == 0) return 33'd0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = mag << (23 - p);
      r = 0;
    end else begin
      shift = p - 23;
      q     = mag >> shift;
      r     = mag - (q << shift);
      half  = longint'(1) << (shift - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {s, 8'(p + 127), q[22:0], r != 0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, sample 1 ns later, scoreboard both transfers.
  task automatic cycle(input logic iv, input logic [31:0] xv, input logic ordy,
                       input logic has_exp, input logic [32:0] expv);
    in_valid  = iv;
    x         = xv;
    out_ready = ordy;
    #1;
    popped = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious: got y=%h, expected no output", y);
      end else begin
        logic [32:0] e = exp_q.pop_front();
        check("y", y, e[32:1]);
`ifdef ITOF_INEXACT_EN
        check("inexact", {31'b0, inexact}, {31'b0, e[0]});
`endif
      end
      popped = 1'b1;
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (in_valid && in_ready) exp_q.push_back(has_exp ? expv : model(xv));
    cyc++;
    @(negedge clk);
  endtask

  task automatic push_vec(input int i);
    cycle(1'b1, vecs[i].x, 1'b1, 1'b1, {vecs[i].y, vecs[i].inx});
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{32'h8000_0000, 32'hCF00_0000, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
    vecs[5]  = '{32'd16777217,  32'h4B80_0000, 1'b1};
    vecs[6]  = '{32'd16777219,  32'h4B80_0002, 1'b1};
    vecs[7]  = '{32'h0000_0002, 32'h4000_0000, 1'b0};
    vecs[8]  = '{32'h0000_0003, 32'h4040_0000, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0};
    vecs[10] = '{32'd16777216,  32'h4B80_0000, 1'b0};
    vecs[11] = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_y", y, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ITOF_INEXACT_EN
    check("reset_inexact", {31'b0, inexact}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Isolated items: exact 3-cycle latency.
    for (int i = 0; i < 4; i++) begin
      push_vec(i);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        cycle(1'b0, '0, 1'b1, 1'b0, '0);
        if (popped) begin
          lat = k;
          break;
        end
      end
      check("latency", lat, 3);
    end

    // Eight back-to-back items emerge on consecutive cycles.
    pop_cnt   = 0;
    first_pop = -1;
    for (int i = 4; i < 12; i++) push_vec(i);
    drain();
    check("stream_pops", pop_cnt, 8);
    check("stream_span", last_pop - first_pop + 1, 8);

    // Fill, then stall 5 cycles with a pending input.
    for (int i = 4; i < 7; i++) push_vec(i);
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      x         = vecs[7].x;
      out_ready = 1'b0;
      #1;
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_y", y, exp_q[0][32:1]);
      @(negedge clk);
    end
    push_vec(7);
    drain();

    // Reset with two items in flight drops them.
    push_vec(8);
    push_vec(9);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
    push_vec(5);
    push_vec(6);
    push_vec(3);
    drain();

    // Random stream with random bubbles and backpressure.
    for (int n = 0; n < 20000; n++) begin
      logic        iv, ordy;
      logic [31:0] xv;
      int          sel;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      sel  = $urandom_range(0, 7);
      if (sel == 0)      xv = vecs[$urandom_range(0, 11)].x;
      else if (sel == 1) xv = 32'($urandom_range(0, 4000)) - 32'd2000;
      else if (sel == 2) xv = $urandom >> $urandom_range(0, 31);
      else               xv = $urandom;
      cycle(iv, xv, ordy, 1'b0, '0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
